// File: rtl/uart_rx_pkg.sv
// Shared types and sample-window constants for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Offsets around the mid-bit count (Prescale/2) where the line is sampled and acted on.
    localparam logic [5:0] SMP_EARLY_OFS = 6'd1;
    localparam logic [5:0] SMP_LATE_OFS  = 6'd1;
    localparam logic [5:0] VOTE_OFS      = 6'd2;
    localparam logic [5:0] ACT_OFS       = 6'd3;

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures three line samples around mid-bit and registers their 2-of-3 majority.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] mid,
    output logic       maj,
    output logic       bit_q
);

    logic [2:0] smp_q, smp_d;
    logic       bit_d;

    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_comb begin
        smp_d = smp_q;
        bit_d = bit_q;
        if (edge_cnt == mid - SMP_EARLY_OFS) smp_d[0] = rx_in;
        if (edge_cnt == mid)                 smp_d[1] = rx_in;
        if (edge_cnt == mid + SMP_LATE_OFS)  smp_d[2] = rx_in;
        if (edge_cnt == mid + VOTE_OFS)      bit_d    = maj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q <= 3'b000;
            bit_q <= 1'b0;
        end else begin
            smp_q <= smp_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// 8-bit UART receiver: oversampled frame FSM with optional parity and stop check.
//   state  | meaning
//   IDLE   | line idle, waiting for a low level
//   START  | confirming the start bit (high majority = glitch)
//   DATA   | shifting in 8 data bits LSB first
//   PARITY | checking the parity bit
//   STOP   | checking the stop bit, publishing the frame result
module uart_rx_top
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       PAR_TYP,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       RX_IN,
    output logic [7:0] P_DATA,
    output logic       Data_valid,
    output logic       Parity_Error,
    output logic       Stop_Error
);

    rx_state_e  state_q, state_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] p_data_q, p_data_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       par_flag_q, par_flag_d;
    logic       stop_flag_q, stop_flag_d;
    logic       dv_q, dv_d;
    logic       pe_q, pe_d;
    logic       se_q, se_d;

    logic [5:0] mid, last_edge, vote_pt, act_pt;
    logic       maj, bit_q;

    assign mid       = {1'b0, Prescale[5:1]};
    assign last_edge = Prescale - 6'd1;
    assign vote_pt   = mid + VOTE_OFS;
    assign act_pt    = mid + ACT_OFS;

    uart_rx_sampler u_sampler (
        .clk      (CLK),
        .rst      (RST),
        .rx_in    (RX_IN),
        .edge_cnt (edge_cnt_q),
        .mid      (mid),
        .maj      (maj),
        .bit_q    (bit_q)
    );

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = (edge_cnt_q == last_edge) ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        par_flag_d  = par_flag_q;
        stop_flag_d = stop_flag_q;
        dv_d        = dv_q;
        pe_d        = pe_q;
        se_d        = se_q;

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = 3'd0;
                if (!RX_IN) begin
                    state_d     = ST_START;
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                    par_flag_d  = 1'b0;
                    stop_flag_d = 1'b0;
                    dv_d        = 1'b0;
                    pe_d        = 1'b0;
                    se_d        = 1'b0;
                end
            end
            ST_START: begin
                // Decide on the fresh vote so a glitch releases the FSM as early as possible.
                if (edge_cnt_q == vote_pt && maj) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = 6'd0;
                end else if (edge_cnt_q == last_edge) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (edge_cnt_q == act_pt) shift_d = {bit_q, shift_q[7:1]};
                if (edge_cnt_q == last_edge) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (edge_cnt_q == act_pt) par_flag_d = bit_q ^ (^shift_q) ^ par_typ_q;
                if (edge_cnt_q == last_edge) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (edge_cnt_q == vote_pt) stop_flag_d = ~maj;
                // Leave mid-bit so a start bit immediately after the stop bit is still caught.
                if (edge_cnt_q == act_pt) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = 6'd0;
                    p_data_d   = shift_q;
                    pe_d       = par_flag_q;
                    se_d       = stop_flag_q;
                    dv_d       = ~par_flag_q & ~stop_flag_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            edge_cnt_q  <= 6'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            p_data_q    <= 8'h00;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            par_flag_q  <= 1'b0;
            stop_flag_q <= 1'b0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            p_data_q    <= p_data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            par_flag_q  <= par_flag_d;
            stop_flag_q <= stop_flag_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            se_q        <= se_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_valid   = dv_q;
    assign Parity_Error = pe_q;
    assign Stop_Error   = se_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Frame-level bench for uart_rx_top: serialises bytes and compares each frame result
// against the outcome predicted from the frame contents.
module tb_uart_rx_top;
    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       par_typ;
    logic       par_en;
    logic [5:0] presc;
    logic       rx_in;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    always #5 clk = ~clk;

    uart_rx_top dut (
        .CLK          (clk),
        .RST          (rst),
        .PAR_TYP      (par_typ),
        .PAR_EN       (par_en),
        .Prescale     (presc),
        .RX_IN        (rx_in),
        .P_DATA       (p_data),
        .Data_valid   (data_valid),
        .Parity_Error (parity_error),
        .Stop_Error   (stop_error)
    );

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    res_t last_exp;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_any = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (prescale %0d, t=%0t)", tag, obs, exp, presc, $time);
        end
    endtask

    // A frame result appears as a rise of any status flag; start detection drops them all.
    always @(negedge clk) begin
        if ((data_valid | parity_error | stop_error) && !prev_any)
            got_q.push_back('{p_data, data_valid, parity_error, stop_error});
        prev_any <= data_valid | parity_error | stop_error;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_cyc(int'(presc));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic par_bad, input logic stop_bit, input logic cfg_flip);
        res_t e;
        e.data = d;
        e.pe   = pen & par_bad;
        e.se   = ~stop_bit;
        e.dv   = ~e.pe & ~e.se;
        exp_q.push_back(e);
        last_exp = e;
        par_en  = pen;
        par_typ = ptyp;
        send_bit(1'b0);
        if (cfg_flip) begin
            par_en  = 1'($urandom_range(0, 1));
            par_typ = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit((^d) ^ ptyp ^ par_bad);
        send_bit(stop_bit);
        rx_in   = 1'b1;
        par_en  = pen;
        par_typ = ptyp;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
    endtask

    task automatic drain();
        res_t g, e;
        check_eq("frame_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq("p_data", g.data, e.data);
            check_eq("flags_dv_pe_se", {g.dv, g.pe, g.se}, {e.dv, e.pe, e.se});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag, input res_t e);
        check_eq({tag, "_p_data"}, p_data, e.data);
        check_eq({tag, "_flags"}, {data_valid, parity_error, stop_error}, {e.dv, e.pe, e.se});
    endtask

    int   pres_tab[3] = '{8, 16, 32};
    int   gmin;
    int   n;
    res_t zero_res;
    logic stop_ok;

    initial begin
        zero_res = '{8'h00, 1'b0, 1'b0, 1'b0};
        rst      = 1'b1;
        rx_in    = 1'b1;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        presc    = 6'd8;
        wait_cyc(3);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            presc = 6'(pres_tab[k]);
            pulse_reset();
            wait_cyc(2);
            check_eq("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
            check_outputs("reset", zero_res);

            // At Prescale 8 the STOP exit lands on the next bit's first cycle, so a
            // start bit arriving with no guard would be detected one cycle late.
            gmin = (presc == 6'd8) ? 1 : 0;

            send_frame(8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            wait_cyc(2 * int'(presc));
            send_frame(8'h8E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            wait_cyc(gmin);
            send_frame(8'h3B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            wait_cyc(gmin);
            send_frame(8'h8E, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            wait_cyc(gmin);
            send_frame(8'h3B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            wait_cyc(2 * int'(presc));
            send_frame(8'h8E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            wait_cyc(2 * int'(presc));
            send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            wait_cyc(2 * int'(presc));

            for (int f = 0; f < 12; f++) begin
                stop_ok = ($urandom_range(0, 4) != 0);
                send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                           stop_ok, 1'($urandom_range(0, 1)));
                wait_cyc(stop_ok ? gmin + int'($urandom_range(0, 3)) : 2 * int'(presc));
            end
            send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            wait_cyc(2 * int'(presc));
            drain();
            check_outputs("hold", last_exp);

            // Abort a frame with reset, then make sure nothing restarts on a high line.
            wait_cyc(3 * int'(presc));
            send_bit(1'b0);
            send_bit(1'b1);
            send_bit(1'b0);
            send_bit(1'b1);
            pulse_reset();
            wait_cyc(2 * int'(presc));
            check_eq("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
            check_outputs("abort", zero_res);

            // One-cycle low glitch must fall back to IDLE within Prescale/2+3 cycles.
            rx_in = 1'b0;
            wait_cyc(1);
            rx_in = 1'b1;
            n = 0;
            while (dut.state_q != ST_IDLE && n < int'(presc) / 2 + 3) begin
                wait_cyc(1);
                n++;
            end
            check_eq("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
            wait_cyc(int'(presc));
            check_outputs("glitch", zero_res);
            check_eq("glitch_no_frame", got_q.size(), 0);
            got_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
